// File: rtl/req_ack_pkg.sv
// Shared state encoding for the request/ack service blocks and their checkers.
package req_ack_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 2'd0,
        STARTING = 2'd1,
        WORKING  = 2'd2,
        DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/req_ack_rr_timer_svc_timer.sv
// Service timer: cleared on start, counts while enabled, flags ready when it reaches the latched limit.
module svc_timer #(
    parameter int CNT_W = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             ready
);

    logic [CNT_W-1:0] count;

    assign ready = en && (count == limit);

    // Holding at the limit keeps an all-ones limit from wrapping the counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (en && !ready) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/req_ack_rr_timer.sv
// N_CH requesters share one service timer; idle requests are granted round-robin and
// answered with a one-cycle ack after a programmable delay.
import req_ack_pkg::*;

module req_ack_rr_timer #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 10,
    parameter int ID_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_CH-1:0]  req,
    input  logic [CNT_W-1:0] delay,
    output logic [N_CH-1:0]  ack,
    output logic             busy,
    output logic [ID_W-1:0]  grant_id
);

    state_t           state;
    state_t           state_nxt;
    logic [ID_W-1:0]  ptr;
    logic [CNT_W-1:0] limit;
    logic [ID_W-1:0]  pick;
    logic             start;
    logic             en;
    logic             ready;

    // First asserted channel scanning upward from the one after the last grant.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_CH-1:0] r,
                                                input logic [ID_W-1:0] last);
        logic [ID_W-1:0] g;
        logic            found;
        int              idx;
        g     = last;
        found = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = (int'(last) + i) % N_CH;
            if (!found && r[idx]) begin
                g     = ID_W'(idx);
                found = 1'b1;
            end
        end
        return g;
    endfunction

    assign pick  = rr_pick(req, ptr);
    assign start = (state == STARTING);
    assign en    = (state == WORKING);

    svc_timer #(.CNT_W(CNT_W)) u_timer (
        .clock (clock),
        .reset (reset),
        .start (start),
        .en    (en),
        .limit (limit),
        .ready (ready)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= ID_W'(N_CH - 1);
            grant_id <= '0;
            limit    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (|req)) begin
                grant_id <= pick;
                ptr      <= pick;
                limit    <= delay;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (|req) state_nxt = STARTING;
            STARTING: state_nxt = WORKING;
            WORKING:  if (ready) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs decode registered state only, so req has no combinational path out.
    assign busy = (state != IDLE);
    assign ack  = (state == DONE) ? (N_CH'(1) << grant_id) : '0;

endmodule

// File: tb/tb_req_ack_rr_timer.sv
// Directed bench for req_ack_rr_timer with a busy-countdown reference model checked every cycle.
module tb_req_ack_rr_timer;

    localparam int N_CH  = 4;
    localparam int CNT_W = 10;
    localparam int ID_W  = 2;

    logic             clock;
    logic             reset;
    logic [N_CH-1:0]  req;
    logic [CNT_W-1:0] delay;
    logic [N_CH-1:0]  ack;
    logic             busy;
    logic [ID_W-1:0]  grant_id;

    int vectors = 0;
    int fails   = 0;

    req_ack_rr_timer #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .delay    (delay),
        .ack      (ack),
        .busy     (busy),
        .grant_id (grant_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: a grant occupies the block for delay+3 cycles (start, delay+1
    // timer cycles, ack cycle); ack shows in the last of them.
    int  m_left  = 0;
    int  m_grant = 0;
    int  m_ptr   = N_CH - 1;
    bit  m_valid = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_left  = 0;
            m_grant = 0;
            m_ptr   = N_CH - 1;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
        end else if (req != '0) begin
            for (int k = 1; k <= N_CH; k++) begin
                if (req[(m_ptr + k) % N_CH]) begin
                    m_grant = (m_ptr + k) % N_CH;
                    break;
                end
            end
            m_ptr  = m_grant;
            m_left = int'(delay) + 3;
        end
        m_valid = 1;
    end

    always @(negedge clock) begin
        if (m_valid) begin
            logic [N_CH-1:0] exp_ack;
            exp_ack = (m_left == 1) ? (N_CH'(1) << m_grant) : '0;
            vectors++;
            if (ack !== exp_ack) begin
                fails++;
                $display("FAIL model_ack t=%0t got %b want %b", $time, ack, exp_ack);
            end
            if (busy !== (m_left > 0)) begin
                fails++;
                $display("FAIL model_busy t=%0t got %b want %b", $time, busy, (m_left > 0));
            end
            if (m_left > 0 && grant_id !== ID_W'(m_grant)) begin
                fails++;
                $display("FAIL model_grant_id t=%0t got %0d want %0d", $time, grant_id, m_grant);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Starting at a negedge, count edges until ack is seen at a following negedge.
    task automatic run_until_ack(input int bound, output int n, output logic [N_CH-1:0] a);
        n = 0;
        a = '0;
        while (n < bound) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (ack != '0) begin
                a = ack;
                break;
            end
        end
        if (a == '0) begin
            fails++;
            $display("FAIL ack_timeout got none within %0d edges", bound);
        end
    endtask

    int              n;
    logic [N_CH-1:0] a;
    logic [N_CH-1:0] order [5];

    initial begin
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;

        // Reset held with all channels requesting
        reset = 1'b1;
        req   = 4'b1111;
        delay = '0;
        repeat (3) begin
            @(negedge clock);
            check("reset_ack", int'(ack), 0);
            check("reset_busy", int'(busy), 0);
        end
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("first_grant_id", int'(grant_id), 0);
        check("first_busy", int'(busy), 1);

        // All channels held, delay 0: ch0,1,2,3,0 with 4-cycle spacing
        for (int i = 0; i < 5; i++) begin
            run_until_ack(50, n, a);
            check($sformatf("rr_ack_%0d", i), int'(a), int'(order[i]));
            check($sformatf("rr_gap_%0d", i), n, (i == 0) ? 2 : 4);
        end
        req = '0;
        @(negedge clock);

        // Single pulsed request on ch2, delay 3
        req   = 4'b0100;
        delay = 10'd3;
        @(posedge clock);
        @(negedge clock);
        req = '0;
        check("ch2_grant_id", int'(grant_id), 2);
        run_until_ack(50, n, a);
        check("ch2_latency", n, 5);
        check("ch2_ack", int'(a), 4'b0100);
        @(negedge clock);
        check("ch2_ack_width", int'(ack), 0);

        // Maximum delay, ch0 alone
        req   = 4'b0001;
        delay = 10'd1023;
        @(posedge clock);
        @(negedge clock);
        req = '0;
        run_until_ack(1200, n, a);
        check("max_latency", n, 1025);
        check("max_ack", int'(a), 4'b0001);
        @(negedge clock);

        // Reset in WORKING with count 5, limit 10
        req   = 4'b0010;
        delay = 10'd10;
        @(posedge clock);
        @(negedge clock);
        req = '0;
        repeat (6) @(posedge clock);
        @(negedge clock);
        check("abort_busy_before", int'(busy), 1);
        reset = 1'b1;
        @(negedge clock);
        check("abort_busy", int'(busy), 0);
        check("abort_ack", int'(ack), 0);
        reset = 1'b0;
        repeat (12) begin
            @(negedge clock);
            check("abort_no_ack", int'(ack), 0);
        end
        req   = 4'b0100;
        delay = 10'd1;
        @(posedge clock);
        @(negedge clock);
        req = '0;
        check("post_reset_grant", int'(grant_id), 2);
        run_until_ack(50, n, a);
        check("post_reset_latency", n, 3);
        check("post_reset_ack", int'(a), 4'b0100);
        @(negedge clock);

        // Fairness between ch0/ch1 and a late request on ch3
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        req   = 4'b0011;
        delay = 10'd1;
        @(posedge clock);
        @(negedge clock);
        run_until_ack(50, n, a);
        check("fair_first_ack", int'(a), 4'b0001);
        check("fair_first_latency", n, 3);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        req = 4'b1011;
        check("fair_second_grant", int'(grant_id), 1);
        run_until_ack(50, n, a);
        check("fair_second_ack", int'(a), 4'b0010);
        check("fair_second_latency", n, 3);
        run_until_ack(50, n, a);
        check("late_req_ack", int'(a), 4'b1000);
        check("late_req_gap", n, 5);
        req = '0;
        repeat (4) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
